// File: rtl/axis_hdr_pkg.sv
// ============================================================================
// Module      : axis_hdr_pkg
// Description : Shared keep-mask helpers and FSM encoding for the AXI-Stream
//               header insert/extract blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axis_hdr_pkg;

    // Widest beat any user of these helpers may instantiate (512-bit data).
    localparam int MAX_BYTES = 64;

    typedef logic [MAX_BYTES-1:0] keep_max_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BODY  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    function automatic int keep_count(input keep_max_t k);
        int cnt;
        cnt = 0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            cnt += int'(k[i]);
        end
        return cnt;
    endfunction

    function automatic keep_max_t keep_right(input int k);
        if (k <= 0) begin
            return '0;
        end
        if (k >= MAX_BYTES) begin
            return '1;
        end
        return (keep_max_t'(1) << k) - keep_max_t'(1);
    endfunction

    // Mask of k ones packed against the MSB of an nbytes-wide keep field.
    function automatic keep_max_t keep_left(input int k, input int nbytes);
        if (k <= 0) begin
            return '0;
        end
        if (k >= nbytes) begin
            return keep_right(nbytes);
        end
        return keep_right(k) << (nbytes - k);
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_stream_extract_header_if.sv
// ============================================================================
// Module      : axi_stream_extract_header_if
// Description : Input stream, header port and payload stream of the header
//               extractor, bundled with source/sink modports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi_stream_extract_header_if #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int LEN_WD       = $clog2(DATA_BYTE_WD + 1)
) ();

    logic                    valid_in;
    logic                    ready_in;
    logic [DATA_WD-1:0]      data_in;
    logic [DATA_BYTE_WD-1:0] keep_in;
    logic                    last_in;
    logic [LEN_WD-1:0]       hdr_len;

    logic                    valid_hdr;
    logic                    ready_hdr;
    logic [DATA_WD-1:0]      header_out;
    logic [DATA_BYTE_WD-1:0] keep_hdr;

    logic                    valid_out;
    logic                    ready_out;
    logic [DATA_WD-1:0]      data_out;
    logic [DATA_BYTE_WD-1:0] keep_out;
    logic                    last_out;

    // The extractor itself.
    modport slave (
        input  valid_in, data_in, keep_in, last_in, hdr_len, ready_hdr, ready_out,
        output ready_in, valid_hdr, header_out, keep_hdr,
               valid_out, data_out, keep_out, last_out
    );

    // The environment: link-side source plus header/payload sinks.
    modport master (
        output valid_in, data_in, keep_in, last_in, hdr_len, ready_hdr, ready_out,
        input  ready_in, valid_hdr, header_out, keep_hdr,
               valid_out, data_out, keep_out, last_out
    );

endinterface

`default_nettype wire

// File: rtl/axis_byte_merge.sv
// ============================================================================
// Module      : axis_byte_merge
// Description : Combinational byte realignment: top bytes from the residue,
//               shifted up by h, followed by the top h bytes of the new beat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_byte_merge #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int LEN_WD       = $clog2(DATA_BYTE_WD + 1)
) (
    input  wire logic [DATA_WD-1:0] i_residue,
    input  wire logic [DATA_WD-1:0] i_data,
    input  wire logic [LEN_WD-1:0]  i_h,
    output logic      [DATA_WD-1:0] o_merged
);

    int w_h;

    always_comb begin
        w_h = int'(i_h);
        // h=0 means the residue is a whole beat; h=full means it is empty.
        if (w_h == 0) begin
            o_merged = i_residue;
        end else if (w_h >= DATA_BYTE_WD) begin
            o_merged = i_data;
        end else begin
            o_merged = (i_residue << (8 * w_h)) | (i_data >> (8 * (DATA_BYTE_WD - w_h)));
        end
    end

endmodule

`default_nettype wire

// File: rtl/axi_stream_extract_header.sv
// ============================================================================
// Module      : axi_stream_extract_header
// Description : Strips h leading header bytes off each AXI-Stream packet onto
//               a header port and repacks the remaining payload MSB-first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_stream_extract_header
    import axis_hdr_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int LEN_WD       = $clog2(DATA_BYTE_WD + 1)
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    axi_stream_extract_header_if.slave bus
);

    localparam logic [DATA_BYTE_WD-1:0] c_keep_full = '1;

    state_t                  r_state;
    logic [LEN_WD-1:0]       r_h;
    logic [LEN_WD-1:0]       r_flush_n;
    logic [DATA_WD-1:0]      r_residue;
    logic                    r_valid_out;
    logic                    r_last_out;
    logic [DATA_WD-1:0]      r_data_out;
    logic [DATA_BYTE_WD-1:0] r_keep_out;
    logic                    r_valid_hdr;
    logic [DATA_WD-1:0]      r_header;
    logic [DATA_BYTE_WD-1:0] r_keep_hdr;

    int                      w_h;
    int                      w_n;
    int                      w_c;
    logic                    w_out_free;
    logic                    w_ready_in;
    logic                    w_accept;
    logic                    w_split_last;
    logic [DATA_WD-1:0]      w_merge_res;
    logic [DATA_WD-1:0]      w_merge_dat;
    logic [DATA_WD-1:0]      w_merged;
    logic [DATA_WD-1:0]      w_header;
    logic [DATA_WD-1:0]      w_pay_mask;
    logic [DATA_WD-1:0]      w_pay_data;
    logic [DATA_BYTE_WD-1:0] w_pay_keep;
    logic                    w_pay_last;
    logic                    w_pay_emit;
    state_t                  w_next;

    assign w_out_free = !r_valid_out || bus.ready_out;
    assign w_ready_in = rst_n && (r_state != ST_FLUSH) && w_out_free &&
                        ((r_state != ST_IDLE) || !r_valid_hdr || bus.ready_hdr);
    assign w_accept   = bus.valid_in && w_ready_in;

    always_comb begin
        // Header length is live only on a first beat; afterwards the latched copy rules.
        w_h = (r_state == ST_IDLE) ? int'(bus.hdr_len) : int'(r_h);
        if (w_h > DATA_BYTE_WD) begin
            w_h = DATA_BYTE_WD;
        end
        w_n          = keep_count(keep_max_t'(bus.keep_in));
        w_c          = DATA_BYTE_WD - w_h + w_n;
        w_split_last = (r_state == ST_BODY) && bus.last_in && (w_c > DATA_BYTE_WD);
        w_header     = bus.data_in >> (8 * (DATA_BYTE_WD - w_h));
        w_merge_res  = (r_state == ST_IDLE) ? bus.data_in : r_residue;
        w_merge_dat  = (r_state == ST_BODY) ? bus.data_in : '0;
    end

    axis_byte_merge #(
        .DATA_WD      (DATA_WD),
        .DATA_BYTE_WD (DATA_BYTE_WD),
        .LEN_WD       (LEN_WD)
    ) u_merge (
        .i_residue (w_merge_res),
        .i_data    (w_merge_dat),
        .i_h       (LEN_WD'(w_h)),
        .o_merged  (w_merged)
    );

    always_comb begin
        w_pay_emit = 1'b0;
        w_pay_last = 1'b0;
        w_pay_keep = '0;
        w_next     = r_state;
        case (r_state)
            ST_IDLE: begin
                w_pay_emit = bus.last_in && (w_n > w_h);
                w_pay_last = 1'b1;
                w_pay_keep = DATA_BYTE_WD'(keep_left(w_n - w_h, DATA_BYTE_WD));
                w_next     = bus.last_in ? ST_IDLE : ST_BODY;
            end
            ST_BODY: begin
                w_pay_emit = 1'b1;
                if (bus.last_in && !w_split_last) begin
                    w_pay_last = 1'b1;
                    w_pay_keep = DATA_BYTE_WD'(keep_left(w_c, DATA_BYTE_WD));
                    w_next     = ST_IDLE;
                end else begin
                    w_pay_keep = c_keep_full;
                    w_next     = w_split_last ? ST_FLUSH : ST_BODY;
                end
            end
            ST_FLUSH: begin
                w_pay_emit = 1'b1;
                w_pay_last = 1'b1;
                w_pay_keep = DATA_BYTE_WD'(keep_left(int'(r_flush_n), DATA_BYTE_WD));
                w_next     = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Bytes outside keep are forced to zero so stale input bytes never leak out.
    generate
        for (genvar gi = 0; gi < DATA_BYTE_WD; gi++) begin : g_pay_mask
            assign w_pay_mask[8*gi +: 8] = {8{w_pay_keep[gi]}};
        end
    endgenerate

    assign w_pay_data = w_merged & w_pay_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_h         <= '0;
            r_flush_n   <= '0;
            r_residue   <= '0;
            r_valid_out <= 1'b0;
            r_last_out  <= 1'b0;
            r_data_out  <= '0;
            r_keep_out  <= '0;
            r_valid_hdr <= 1'b0;
            r_header    <= '0;
            r_keep_hdr  <= '0;
        end else begin
            if (r_valid_out && bus.ready_out) begin
                r_valid_out <= 1'b0;
            end
            if (r_valid_hdr && bus.ready_hdr) begin
                r_valid_hdr <= 1'b0;
            end
            if (w_accept) begin
                r_residue <= bus.data_in;
                r_state   <= w_next;
                if (r_state == ST_IDLE) begin
                    r_h <= LEN_WD'(w_h);
                    if (w_h != 0) begin
                        r_valid_hdr <= 1'b1;
                        r_header    <= w_header;
                        r_keep_hdr  <= DATA_BYTE_WD'(keep_right(w_h));
                    end
                end
                if (w_split_last) begin
                    r_flush_n <= LEN_WD'(w_n - w_h);
                end
                if (w_pay_emit) begin
                    r_valid_out <= 1'b1;
                    r_last_out  <= w_pay_last;
                    r_data_out  <= w_pay_data;
                    r_keep_out  <= w_pay_keep;
                end
            end else if ((r_state == ST_FLUSH) && w_out_free) begin
                r_valid_out <= 1'b1;
                r_last_out  <= w_pay_last;
                r_data_out  <= w_pay_data;
                r_keep_out  <= w_pay_keep;
                r_state     <= w_next;
            end
        end
    end

    assign bus.ready_in   = w_ready_in;
    assign bus.valid_out  = r_valid_out;
    assign bus.last_out   = r_last_out;
    assign bus.data_out   = r_data_out;
    assign bus.keep_out   = r_keep_out;
    assign bus.valid_hdr  = r_valid_hdr;
    assign bus.header_out = r_header;
    assign bus.keep_hdr   = r_keep_hdr;

endmodule

`default_nettype wire

// File: tb/tb_axi_stream_extract_header.sv
// ============================================================================
// Module      : tb_axi_stream_extract_header
// Description : Scoreboard bench for the header extractor (32-bit data).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_stream_extract_header;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
    } hdr_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_fail;

    beat_t exp_pay[$];
    hdr_t  exp_hdr[$];

    logic [31:0] pkt_d[8];
    logic [3:0]  pkt_k[8];
    int          pkt_n;

    axi_stream_extract_header_if #(.DATA_WD(32)) bus ();

    axi_stream_extract_header #(.DATA_WD(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every handshaken output beat is matched against the model.
    always @(negedge clk) begin
        if (bus.valid_out && bus.ready_out) begin
            n_vec++;
            if (exp_pay.size() == 0) begin
                n_fail++;
                $display("FAIL payload_extra: got %h/%b/%b, expected no beat",
                         bus.data_out, bus.keep_out, bus.last_out);
            end else begin
                beat_t e;
                e = exp_pay.pop_front();
                if ({bus.data_out, bus.keep_out, bus.last_out} !== e) begin
                    n_fail++;
                    $display("FAIL payload_beat: got %h/%b/%b, expected %h/%b/%b",
                             bus.data_out, bus.keep_out, bus.last_out, e.d, e.k, e.l);
                end
            end
        end
        if (bus.valid_hdr && bus.ready_hdr) begin
            n_vec++;
            if (exp_hdr.size() == 0) begin
                n_fail++;
                $display("FAIL header_extra: got %h/%b, expected no header",
                         bus.header_out, bus.keep_hdr);
            end else begin
                hdr_t e;
                e = exp_hdr.pop_front();
                if ({bus.header_out, bus.keep_hdr} !== e) begin
                    n_fail++;
                    $display("FAIL header_beat: got %h/%b, expected %h/%b",
                             bus.header_out, bus.keep_hdr, e.d, e.k);
                end
            end
        end
    end

    // Byte-level reference: header is the first h bytes, payload is the rest repacked.
    task automatic model_packet(input int h);
        logic [7:0]  bytes[$];
        logic [31:0] hd;
        beat_t       b;
        int          idx;
        int          m;
        for (int i = 0; i < pkt_n; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (pkt_k[i][3-j]) bytes.push_back(pkt_d[i][31-8*j -: 8]);
            end
        end
        if (h > 0) begin
            hd = '0;
            for (int j = 0; j < h; j++) hd = (hd << 8) | 32'(pkt_d[0][31-8*j -: 8]);
            exp_hdr.push_back({hd, 4'((1 << h) - 1)});
        end
        idx = h;
        while (idx < bytes.size()) begin
            m = bytes.size() - idx;
            if (m > 4) m = 4;
            b = '0;
            for (int j = 0; j < m; j++) begin
                b.d[31-8*j -: 8] = bytes[idx+j];
                b.k[3-j]         = 1'b1;
            end
            idx += m;
            b.l = (idx == bytes.size());
            exp_pay.push_back(b);
        end
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k,
                             input logic l, input logic [2:0] h);
        int   cyc;
        logic rdy;
        bus.valid_in = 1'b1;
        bus.data_in  = d;
        bus.keep_in  = k;
        bus.last_in  = l;
        bus.hdr_len  = h;
        cyc = 0;
        forever begin
            @(negedge clk);
            rdy = bus.ready_in;
            @(posedge clk);
            #1;
            if (rdy) break;
            cyc++;
            if (cyc > 100) begin
                n_vec++;
                n_fail++;
                $display("FAIL send_timeout: ready_in stayed %b, expected 1", rdy);
                break;
            end
        end
        bus.valid_in = 1'b0;
        // Changing hdr_len mid-packet must not matter.
        bus.hdr_len  = 3'($urandom_range(0, 4));
    endtask

    task automatic send_packet(input int h);
        for (int i = 0; i < pkt_n; i++) begin
            send_beat(pkt_d[i], pkt_k[i], i == pkt_n - 1, (i == 0) ? 3'(h) : bus.hdr_len);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (exp_pay.size() != 0 || exp_hdr.size() != 0); i++) begin
            @(posedge clk);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.valid_in  = 1'b0;
        bus.data_in   = '0;
        bus.keep_in   = '0;
        bus.last_in   = 1'b0;
        bus.hdr_len   = '0;
        bus.ready_out = 1'b1;
        bus.ready_hdr = 1'b1;
        repeat (2) @(negedge clk);
        n_vec += 4;
        if (bus.ready_in !== 1'b0) begin n_fail++; $display("FAIL reset_ready_in: got %b, expected 0", bus.ready_in); end
        if ({bus.valid_out, bus.last_out, bus.valid_hdr} !== 3'b000) begin
            n_fail++; $display("FAIL reset_valids: got %b, expected 000", {bus.valid_out, bus.last_out, bus.valid_hdr});
        end
        if ({bus.data_out, bus.keep_out} !== 36'h0) begin
            n_fail++; $display("FAIL reset_data_out: got %h/%b, expected 0", bus.data_out, bus.keep_out);
        end
        if ({bus.header_out, bus.keep_hdr} !== 36'h0) begin
            n_fail++; $display("FAIL reset_header: got %h/%b, expected 0", bus.header_out, bus.keep_hdr);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (bus.ready_in !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b, expected 1", bus.ready_in); end
        @(posedge clk);
        #1;
    endtask

    task automatic check_drained(input string name);
        n_vec++;
        if (exp_pay.size() != 0 || exp_hdr.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d payload / %0d header beats missing, expected 0",
                     name, exp_pay.size(), exp_hdr.size());
        end
    endtask

    task automatic test_h2();
        pkt_n = 3;
        pkt_d[0] = 32'hAABBCCDD; pkt_k[0] = 4'b1111;
        pkt_d[1] = 32'h11223344; pkt_k[1] = 4'b1111;
        pkt_d[2] = 32'h55660000; pkt_k[2] = 4'b1100;
        model_packet(2);
        send_packet(2);
        drain();
        check_drained("h2");
    endtask

    task automatic test_h1_flush();
        pkt_n = 2;
        pkt_d[0] = 32'hAABBCCDD; pkt_k[0] = 4'b1111;
        pkt_d[1] = 32'h11223344; pkt_k[1] = 4'b1110;
        model_packet(1);
        send_packet(1);
        @(negedge clk);
        n_vec++;
        if (bus.ready_in !== 1'b0) begin n_fail++; $display("FAIL flush_bubble: ready_in %b, expected 0", bus.ready_in); end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_vec++;
        if (bus.ready_in !== 1'b1) begin n_fail++; $display("FAIL flush_end: ready_in %b, expected 1", bus.ready_in); end
        drain();
        check_drained("h1");
    endtask

    task automatic test_h0();
        pkt_n = 3;
        pkt_d[0] = 32'h01020304; pkt_k[0] = 4'b1111;
        pkt_d[1] = 32'h05060708; pkt_k[1] = 4'b1111;
        pkt_d[2] = 32'h09000000; pkt_k[2] = 4'b1000;
        model_packet(0);
        send_packet(0);
        drain();
        check_drained("h0");
    endtask

    task automatic test_back_to_back();
        pkt_n = 1;
        pkt_d[0] = 32'hDEADBEEF; pkt_k[0] = 4'b1111;
        model_packet(4);
        send_packet(4);
        pkt_n = 2;
        pkt_d[0] = 32'hA1A2A3A4; pkt_k[0] = 4'b1111;
        pkt_d[1] = 32'hB1B2B3B4; pkt_k[1] = 4'b1111;
        model_packet(2);
        send_packet(2);
        drain();
        check_drained("b2b");
    endtask

    task automatic test_out_backpressure();
        pkt_n = 4;
        pkt_d[0] = 32'h01020304; pkt_k[0] = 4'b1111;
        pkt_d[1] = 32'h05060708; pkt_k[1] = 4'b1111;
        pkt_d[2] = 32'h090A0B0C; pkt_k[2] = 4'b1111;
        pkt_d[3] = 32'h0D0E0000; pkt_k[3] = 4'b1100;
        model_packet(1);
        bus.ready_out = 1'b0;
        send_beat(pkt_d[0], pkt_k[0], 1'b0, 3'd1);
        send_beat(pkt_d[1], pkt_k[1], 1'b0, bus.hdr_len);
        bus.valid_in = 1'b1;
        bus.data_in  = pkt_d[2];
        bus.keep_in  = pkt_k[2];
        bus.last_in  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if ({bus.valid_out, bus.data_out, bus.keep_out, bus.ready_in} !== {1'b1, 32'h02030405, 4'hF, 1'b0}) begin
                n_fail++;
                $display("FAIL out_stall_%0d: got v%b %h/%b rdy%b, expected v1 02030405/1111 rdy0",
                         i, bus.valid_out, bus.data_out, bus.keep_out, bus.ready_in);
            end
            @(posedge clk);
            #1;
        end
        bus.ready_out = 1'b1;
        send_beat(pkt_d[2], pkt_k[2], 1'b0, bus.hdr_len);
        send_beat(pkt_d[3], pkt_k[3], 1'b1, bus.hdr_len);
        drain();
        check_drained("out_bp");
    endtask

    task automatic test_hdr_backpressure();
        bus.ready_hdr = 1'b0;
        pkt_n = 1;
        pkt_d[0] = 32'h01020304; pkt_k[0] = 4'b1111;
        model_packet(2);
        send_packet(2);
        pkt_n = 2;
        pkt_d[0] = 32'hA0A1A2A3; pkt_k[0] = 4'b1111;
        pkt_d[1] = 32'hB0B1B2B3; pkt_k[1] = 4'b1111;
        model_packet(1);
        bus.valid_in = 1'b1;
        bus.data_in  = pkt_d[0];
        bus.keep_in  = pkt_k[0];
        bus.last_in  = 1'b0;
        bus.hdr_len  = 3'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if ({bus.ready_in, bus.valid_hdr, bus.header_out} !== {1'b0, 1'b1, 32'h00000102}) begin
                n_fail++;
                $display("FAIL hdr_stall_%0d: got rdy%b vh%b %h, expected rdy0 vh1 00000102",
                         i, bus.ready_in, bus.valid_hdr, bus.header_out);
            end
            @(posedge clk);
            #1;
        end
        bus.ready_hdr = 1'b1;
        send_packet(1);
        drain();
        check_drained("hdr_bp");
    endtask

    task automatic test_reset_mid();
        pkt_n = 3;
        pkt_d[0] = 32'h10203040; pkt_k[0] = 4'b1111;
        pkt_d[1] = 32'h50607080; pkt_k[1] = 4'b1111;
        pkt_d[2] = 32'h90A0B0C0; pkt_k[2] = 4'b1111;
        model_packet(2);
        send_beat(pkt_d[0], pkt_k[0], 1'b0, 3'd2);
        send_beat(pkt_d[1], pkt_k[1], 1'b0, bus.hdr_len);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.valid_out, bus.valid_hdr, bus.ready_in, bus.data_out, bus.keep_out, bus.header_out} !== 71'h0) begin
            n_fail++;
            $display("FAIL async_reset: got v%b vh%b rdy%b %h/%b hdr %h, expected all 0",
                     bus.valid_out, bus.valid_hdr, bus.ready_in, bus.data_out, bus.keep_out, bus.header_out);
        end
        exp_pay.delete();
        exp_hdr.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_leftover: valid_out %b, expected 0", bus.valid_out); end
        pkt_n = 2;
        pkt_d[0] = 32'h0A0B0C0D; pkt_k[0] = 4'b1111;
        pkt_d[1] = 32'h0E0F1011; pkt_k[1] = 4'b1100;
        model_packet(3);
        send_packet(3);
        drain();
        check_drained("rst_mid");
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;
        test_reset();
        test_h2();
        test_h1_flush();
        test_h0();
        test_back_to_back();
        test_out_backpressure();
        test_hdr_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
